// File: rtl/sensor_conditioner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sensor_conditioner_pkg                                              |
// | Shared channel map and defaults for the irrigation input stage.     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package sensor_conditioner_pkg;

  localparam int N_CH = 6;

  localparam int CH_H  = 0;
  localparam int CH_M  = 1;
  localparam int CH_L  = 2;
  localparam int CH_US = 3;
  localparam int CH_UA = 4;
  localparam int CH_T  = 5;

  localparam int DEF_SAMPLE_DIV     = 50000;
  localparam int DEF_STABLE_SAMPLES = 8;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_conditioner_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sensor_conditioner_if                                               |
// | Raw switch inputs and conditioned outputs of the input stage.       |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface sensor_conditioner_if #(
  parameter int N_CH = sensor_conditioner_pkg::N_CH
);

  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] clean_out;
  logic            change_pulse;
  logic [N_CH-1:0] changed_mask;
  logic            all_settled;

  modport master (
    output raw_in,
    input  clean_out,
    input  change_pulse,
    input  changed_mask,
    input  all_settled
  );

  modport slave (
    input  raw_in,
    output clean_out,
    output change_pulse,
    output changed_mask,
    output all_settled
  );

endinterface
`default_nettype wire

// File: rtl/sensor_conditioner_debounce_channel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | debounce_channel                                                    |
// | Tick-sampled debouncer for one synchronised switch bit.             |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module debounce_channel
  import sensor_conditioner_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter bit RESET_BIT      = 1'b0
) (
  input  wire logic clock,
  input  wire logic Rst,
  input  wire logic i_tick,
  input  wire logic i_sync,
  output logic      o_clean,
  output logic      o_flip,
  output logic      o_busy
);

  localparam int              c_CW   = cnt_width(STABLE_SAMPLES);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(STABLE_SAMPLES - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  logic [c_CW-1:0] r_cnt;
  logic            r_clean;
  logic            r_flip;

  // The flip strobe is registered alongside the level so both change on the same edge.
  always_ff @(posedge clock or negedge Rst) begin
    if (!Rst) begin
      r_cnt   <= '0;
      r_clean <= RESET_BIT;
      r_flip  <= 1'b0;
    end else begin
      r_flip <= 1'b0;
      if (i_tick) begin
        if (i_sync == r_clean) begin
          r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
          r_clean <= ~r_clean;
          r_cnt   <= '0;
          r_flip  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + c_ONE;
        end
      end
    end
  end

  assign o_clean = r_clean;
  assign o_flip  = r_flip;
  assign o_busy  = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/sensor_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sensor_conditioner                                                  |
// | Synchronise, sample and debounce the six panel/sensor switches.     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module sensor_conditioner #(
  parameter int              N_CH           = sensor_conditioner_pkg::N_CH,
  parameter int              SAMPLE_DIV     = sensor_conditioner_pkg::DEF_SAMPLE_DIV,
  parameter int              STABLE_SAMPLES = sensor_conditioner_pkg::DEF_STABLE_SAMPLES,
  parameter logic [N_CH-1:0] RESET_VAL      = '0
) (
  input wire logic            clock,
  input wire logic            Rst,
  sensor_conditioner_if.slave bus
);

  import sensor_conditioner_pkg::*;

  localparam int              c_PW         = cnt_width(SAMPLE_DIV);
  localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(SAMPLE_DIV - 1);
  localparam logic [c_PW-1:0] c_PRESC_ONE  = c_PW'(1);
  localparam int              c_WW         = cnt_width(STABLE_SAMPLES + 1);
  localparam logic [c_WW-1:0] c_WARM_DONE  = c_WW'(STABLE_SAMPLES);
  localparam logic [c_WW-1:0] c_WARM_ONE   = c_WW'(1);

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [c_PW-1:0] r_presc;
  logic [c_WW-1:0] r_warm;
  logic            r_settled;

  logic            w_tick;
  logic            w_warm_done;
  logic [N_CH-1:0] w_clean;
  logic [N_CH-1:0] w_flip;
  logic [N_CH-1:0] w_busy;

  always_ff @(posedge clock or negedge Rst) begin
    if (!Rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.raw_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_presc == c_PRESC_LAST);

  always_ff @(posedge clock or negedge Rst) begin
    if (!Rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + c_PRESC_ONE;
    end
  end

  // Warm-up keeps all_settled low until every channel has seen a full debounce window.
  assign w_warm_done = (r_warm == c_WARM_DONE);

  always_ff @(posedge clock or negedge Rst) begin
    if (!Rst) begin
      r_warm <= '0;
    end else if (w_tick && !w_warm_done) begin
      r_warm <= r_warm + c_WARM_ONE;
    end
  end

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
        .STABLE_SAMPLES (STABLE_SAMPLES),
        .RESET_BIT      (RESET_VAL[i])
      ) u_debounce (
        .clock   (clock),
        .Rst     (Rst),
        .i_tick  (w_tick),
        .i_sync  (r_sync2[i]),
        .o_clean (w_clean[i]),
        .o_flip  (w_flip[i]),
        .o_busy  (w_busy[i])
      );
    end
  endgenerate

  always_ff @(posedge clock or negedge Rst) begin
    if (!Rst) begin
      r_settled <= 1'b0;
    end else begin
      r_settled <= w_warm_done && (w_busy == '0) && (r_sync2 == w_clean);
    end
  end

  // Per-channel flip flags are already registered, so the mask needs no extra stage.
  assign bus.clean_out    = w_clean;
  assign bus.change_pulse = |w_flip;
  assign bus.changed_mask = w_flip;
  assign bus.all_settled  = r_settled;

endmodule
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sensor_conditioner                                               |
// | Random and directed stimulus against a cycle-level reference model. |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_sensor_conditioner;

  localparam int        SD = 4;
  localparam int        SS = 3;
  localparam int        NC = 6;
  localparam logic [5:0] RV = 6'h00;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] raw   = 6'h00;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sensor_conditioner_if #(.N_CH(NC)) bus ();
  assign bus.raw_in = raw;

  sensor_conditioner #(
    .N_CH           (NC),
    .SAMPLE_DIV     (SD),
    .STABLE_SAMPLES (SS),
    .RESET_VAL      (RV)
  ) dut (
    .clock (clk),
    .Rst   (rst_n),
    .bus   (bus.slave)
  );

  // Reference state: what the outputs must be after the next rising edge.
  logic [5:0] m_p0, m_p1, m_clean, m_mask;
  logic       m_settled;
  int         m_cyc, m_warm;
  int         m_run [NC];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p0 = '0; m_p1 = '0; m_clean = RV; m_mask = '0;
    m_settled = 1'b0; m_cyc = 0; m_warm = 0;
    for (int c = 0; c < NC; c++) m_run[c] = 0;
  endtask

  // One rising edge of the specified behaviour, using the inputs present before it.
  task automatic model_step();
    logic [5:0] sync;
    logic       tick, quiet, settled_n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    sync  = m_p1;
    tick  = ((m_cyc % SD) == SD - 1);
    quiet = 1'b1;
    for (int c = 0; c < NC; c++) if (m_run[c] != 0) quiet = 1'b0;
    settled_n = (m_warm >= SS) && quiet && (sync == m_clean);
    m_mask = '0;
    if (tick) begin
      for (int c = 0; c < NC; c++) begin
        if (sync[c] == m_clean[c]) m_run[c] = 0;
        else begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == SS) begin
            m_mask[c] = 1'b1;
            m_run[c]  = 0;
          end
        end
      end
      m_clean = m_clean ^ m_mask;
      if (m_warm < SS) m_warm = m_warm + 1;
    end
    m_settled = settled_n;
    m_p1 = m_p0;
    m_p0 = raw;
    m_cyc = m_cyc + 1;
  endtask

  task automatic compare_model();
    check("clean_out", bus.clean_out, m_clean);
    check("change_pulse", bus.change_pulse, |m_mask);
    check("changed_mask", bus.changed_mask, m_mask);
    check("all_settled", bus.all_settled, m_settled);
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wait_pulse(input string tag, input logic [5:0] exp_mask, input int maxc);
    bit found = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      cycle();
      if (bus.change_pulse) begin
        check({tag, "_mask"}, bus.changed_mask, exp_mask);
        found = 1'b1;
        break;
      end
    end
    if (!found) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int lat, pulses;
    bit ok;
    model_reset();

    // Reset state with all raw inputs high.
    rst_n = 1'b0;
    raw   = 6'h3F;
    run(5);
    check("rst_clean", bus.clean_out, 6'h00);
    check("rst_pulse", bus.change_pulse, 0);
    check("rst_settled", bus.all_settled, 0);

    rst_n  = 1'b1;
    raw    = 6'h00;
    pulses = 0;
    for (int k = 0; k < 14; k++) begin
      cycle();
      pulses += int'(bus.change_pulse);
    end
    check("rel_settled", bus.all_settled, 1);
    check("rel_pulses", pulses, 0);

    // Clean step on H.
    raw = 6'h01;
    lat = 0;
    ok  = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      lat++;
      if (bus.clean_out[0]) begin
        ok = 1'b1;
        break;
      end
    end
    check("step_seen", ok, 1);
    check("step_latency_in_window", (lat >= 10 && lat <= 14), 1);
    check("step_mask", bus.changed_mask, 6'h01);
    run(16);

    // Short glitch on Us.
    raw = 6'h09;
    run(6);
    raw = 6'h01;
    run(20);
    check("glitch_us", bus.clean_out[3], 0);
    check("glitch_settled", bus.all_settled, 1);

    // Simultaneous M and L rise, then L alone drops.
    raw = 6'h00;
    run(20);
    raw = 6'h06;
    wait_pulse("simul", 6'h06, 30);
    check("simul_clean", bus.clean_out, 6'h06);
    run(10);
    raw = 6'h02;
    wait_pulse("drop_l", 6'h04, 30);
    run(16);

    // Timer switch: two high ticks, one low tick, then held high.
    raw = 6'h22;
    run(8);
    raw = 6'h02;
    run(4);
    raw = 6'h22;
    lat = 0;
    ok  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      lat++;
      if (bus.change_pulse) begin
        ok = 1'b1;
        break;
      end
    end
    check("restart_seen", ok, 1);
    check("restart_not_early", (lat >= 11), 1);
    check("restart_mask", bus.changed_mask, 6'h20);
    run(16);

    // Reset in the middle of a count on M.
    raw = 6'h3F;
    run(30);
    check("all_high", bus.clean_out, 6'h3F);
    raw = 6'h3D;
    run(10);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_clean", bus.clean_out, 6'h00);
    check("midrst_pulse", bus.change_pulse, 0);
    check("midrst_mask", bus.changed_mask, 6'h00);
    cycle();
    rst_n = 1'b1;
    wait_pulse("post_rst", 6'h3D, 30);
    check("post_rst_clean", bus.clean_out, 6'h3D);
    run(16);

    // Random segments with long and short holds and occasional resets.
    for (int s = 0; s < 250; s++) begin
      raw = 6'($urandom);
      run($urandom_range(1, 20));
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
      end
    end
    run(30);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
- Upstream input stage for the irrigation controller top level.
- Takes the six raw panel and sensor switch inputs: level probes H/M/L, soil humidity Us, air humidity Ua, and timer/period switch T.
- Per channel, it synchronises the input, samples it on a prescaled tick and debounces it.
- Outputs clean levels to the level/error and irrigation-type logic, plus a change strobe and a settled flag for the display path.

Parameters:
- N_CH, 6, number of conditioned channels.
- SAMPLE_DIV, 50000, clock cycles per sample tick. Must be ≥2. At 50 MHz this gives 1 kHz.
- STABLE_SAMPLES, 8, number of consecutive disagreeing samples required before the clean output flips. Must be ≥2.
- RESET_VAL, 6'b000000, value loaded into clean_out at reset.

Ports:
- clock  in  1  system clock; the only clock.
- Rst  in  1  reset, asynchronous, active-low. Low clears all state immediately.
- raw_in  in  N_CH  raw asynchronous inputs. Bit order: 0=H, 1=M, 2=L, 3=Us, 4=Ua, 5=T.
- clean_out  out  N_CH  debounced levels, same bit order.
- change_pulse  out  1  one-cycle strobe; high when any clean_out bit changed this cycle.
- changed_mask  out  N_CH  bits that flipped, valid while change_pulse=1, zero otherwise.
- all_settled  out  1  high when every channel is stable and warm-up is complete.

Behaviour:
- Reset (Rst=0, async) sets:
  - synchroniser flops = 0
  - prescaler = 0
  - per-channel counters = 0
  - clean_out = RESET_VAL
  - change_pulse = 0, changed_mask = 0
  - warm-up counter = 0, all_settled = 0
- Synchroniser: two flops per bit. sync = raw_in delayed 2 cycles.
- Prescaler: counts 0..SAMPLE_DIV-1 and wraps. tick=1 for one cycle when count==SAMPLE_DIV-1. The first tick after reset release is at cycle SAMPLE_DIV-1.
- Per-channel debounce runs only on tick cycles; non-tick cycles hold all counters.
  - sync[i]==clean_out[i]: counter cleared to 0.
  - sync[i]!=clean_out[i] and counter<STABLE_SAMPLES-1: counter+1.
  - sync[i]!=clean_out[i] and counter==STABLE_SAMPLES-1: clean_out[i] inverts on this edge, counter cleared.
  - A flip therefore needs STABLE_SAMPLES consecutive disagreeing ticks. Any agreeing tick restarts the count. Counter width is clog2(STABLE_SAMPLES).
- Change strobe: change_pulse and changed_mask are registered on the same edge as the clean_out update. They are high for exactly one cycle and zero the next cycle. Simultaneous flips on several channels give one pulse with multiple mask bits set.
- Latency: a clean raw step appears on clean_out between 2+(STABLE_SAMPLES-1)*SAMPLE_DIV+1 and 2+STABLE_SAMPLES*SAMPLE_DIV cycles after the step.
- Warm-up: a saturating counter of ticks since reset. warm_done when it reaches STABLE_SAMPLES.
- all_settled is registered and equals warm_done AND (all counters==0) AND (sync==clean_out). It drops the cycle after any of these conditions fails.
- Reset mid-count: all partial counts are lost and clean_out returns to RESET_VAL. No change_pulse is generated for the reset-induced change.
- Channels are fully independent; no cross-channel plausibility check (e.g. H without L) in this block.

Decomposition:
- Shared package:
  - N_CH
  - channel index constants CH_H=0, CH_M=1, CH_L=2, CH_US=3, CH_UA=4, CH_T=5
  - default SAMPLE_DIV and STABLE_SAMPLES
- Sub-module debounce_channel, one instance per bit:
  - inputs: clock, Rst, tick, sync bit
  - outputs: clean bit, flip strobe, busy (counter≠0)
- Prescaler, synchroniser, warm-up counter and output reduction stay in the parent.

Test Plan (SAMPLE_DIV=4, STABLE_SAMPLES=3, RESET_VAL=0):
- Reset values: hold Rst=0 with raw_in=6'h3F. Expect clean_out=0, change_pulse=0, all_settled=0. After Rst=1 with raw_in=0, expect all_settled=1 by cycle 14 and no change_pulse.
- Clean step: raw_in[0] 0→1 and held. Expect clean_out[0]=1 after 3 disagreeing ticks (10–14 cycles after the step), with a single change_pulse and changed_mask=6'h01. all_settled is low in between.
- Glitch rejection: raw_in[3] high for 6 cycles (≤2 ticks), then low. Expect clean_out[3] stays 0, no change_pulse, and counter[3] returns to 0.
- Simultaneous events: raw_in 0→6'h06 on the same cycle. Expect one change_pulse with changed_mask=6'h06 and clean_out=6'h06. Then set raw_in[2]=0 only. Expect a later pulse with mask 6'h04.
- Restart on agreement: raw_in[5]=1 for 2 ticks, 0 for 1 tick, then 1 held. Expect the flip only 3 ticks after the final rise, not earlier.
- Reset mid-operation: clean_out=6'h3F and raw_in[1] dropped with 2 ticks counted. Assert Rst=0 for 1 cycle. Expect immediate clean_out=0, counters cleared, no change_pulse. On release with raw_in=6'h3D, expect clean_out=6'h3D after 3 ticks with changed_mask=6'h3D.
